// File: rtl/midi_message_parser.sv
// MIDI byte-stream parser: tracks running status, assembles channel-voice events,
// passes real-time bytes straight through and counts orphaned data bytes.
module midi_message_parser #(
  parameter int         OMNI    = 1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       event_valid,
  output logic [2:0] event_type,
  output logic [3:0] event_channel,
  output logic [6:0] event_data1,
  output logic [6:0] event_data2,
  output logic       rt_valid,
  output logic [7:0] rt_code,
  output logic [7:0] stray_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_D1 = 3'd1,
    WAIT_D2 = 3'd2,
    SYSEX   = 3'd3,
    SKIP1   = 3'd4,
    SKIP2   = 3'd5
  } state_t;

  state_t     state;
  logic [2:0] rs_type;
  logic [3:0] rs_chan;
  logic [6:0] data1_q;

  logic       is_rt;
  logic       is_chan;
  logic       is_sys;
  logic       is_data;
  logic       fire;
  logic       pass;
  logic [2:0] ev_type;
  logic [6:0] ev_d1;
  logic [6:0] ev_d2;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Program change and channel pressure carry a single data byte.
  function automatic logic two_data(input logic [2:0] t);
    return !(t == 3'd4 || t == 3'd5);
  endfunction

  always_comb begin
    is_rt   = (byte_data[7:3] == 5'b11111);
    is_chan = byte_data[7] && (byte_data[7:4] != 4'hF);
    is_sys  = (byte_data[7:4] == 4'hF) && !is_rt;
    is_data = !byte_data[7];
    fire    = is_data && ((state == WAIT_D1 && !two_data(rs_type)) || state == WAIT_D2);
    pass    = (OMNI != 0) || (rs_chan == CHANNEL);
    ev_d1   = (state == WAIT_D2) ? data1_q : byte_data[6:0];
    ev_d2   = (state == WAIT_D2) ? byte_data[6:0] : 7'd0;
    // Note-on with zero velocity is the conventional note-off.
    ev_type = (rs_type == 3'd1 && ev_d2 == 7'd0) ? 3'd0 : rs_type;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rs_type       <= 3'd0;
      rs_chan       <= 4'd0;
      data1_q       <= 7'd0;
      event_valid   <= 1'b0;
      event_type    <= 3'd0;
      event_channel <= 4'd0;
      event_data1   <= 7'd0;
      event_data2   <= 7'd0;
      rt_valid      <= 1'b0;
      rt_code       <= 8'd0;
      stray_count   <= 8'd0;
    end else begin
      event_valid <= 1'b0;
      rt_valid    <= 1'b0;
      if (byte_valid) begin
        if (is_rt) begin
          rt_valid <= 1'b1;
          rt_code  <= byte_data;
        end else if (is_chan) begin
          rs_type <= byte_data[6:4];
          rs_chan <= byte_data[3:0];
          state   <= WAIT_D1;
        end else if (is_sys) begin
          rs_type <= 3'd0;
          rs_chan <= 4'd0;
          case (byte_data[3:0])
            4'h0:       state <= SYSEX;
            4'h1, 4'h3: state <= SKIP1;
            4'h2:       state <= SKIP2;
            default:    state <= IDLE;
          endcase
        end else begin
          case (state)
            IDLE:    stray_count <= sat_inc(stray_count);
            WAIT_D1: begin
              if (two_data(rs_type)) begin
                data1_q <= byte_data[6:0];
                state   <= WAIT_D2;
              end
            end
            WAIT_D2: state <= WAIT_D1;
            SKIP2:   state <= SKIP1;
            SKIP1:   state <= IDLE;
            default: ;
          endcase
          if (fire && pass) begin
            event_valid   <= 1'b1;
            event_type    <= ev_type;
            event_channel <= rs_chan;
            event_data1   <= ev_d1;
            event_data2   <= ev_d2;
          end
        end
      end
    end
  end

endmodule
